voice_allocator: RTL and testbench

//  Polyphony scheduler between the piano-key input stage and the oscillator bank of sass_synth.

---
 rtl/sass_pkg.sv | 16 +
 rtl/voice_pick.sv | 64 ++++++
 rtl/voice_allocator.sv | 107 ++++++++++
 tb/tb_voice_allocator.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sass_pkg.sv
// Shared types for the sass_synth voice allocator: key count, note index and voice record.
package sass_pkg;

  localparam int unsigned NUM_KEYS  = 15;
  // Age field is sized for the widest supported AGE_W; unused upper bits stay zero.
  localparam int unsigned AGE_W_MAX = 8;

  typedef logic [3:0] note_t;

  typedef struct packed {
    logic                 active;
    note_t                note;
    logic [AGE_W_MAX-1:0] age;
  } voice_t;

endpackage

// File: rtl/voice_pick.sv
// Combinational voice search: holder of the current key, lowest free voice and,
// when VOICE_STEAL_EN is defined, the oldest voice.
module voice_pick
  import sass_pkg::*;
#(
  parameter int unsigned N_VOICES = 4,
  parameter int unsigned IDX_W    = (N_VOICES > 1) ? $clog2(N_VOICES) : 1
) (
  input  voice_t [N_VOICES-1:0] voices,
  input  note_t                 key,
  output logic                  hit,
  output logic [IDX_W-1:0]      hit_idx,
  output logic                  free,
  output logic [IDX_W-1:0]      free_idx
`ifdef VOICE_STEAL_EN
  ,
  output logic [IDX_W-1:0]      oldest_idx
`endif
);

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int v = N_VOICES - 1; v >= 0; v--) begin
      if (voices[v].active && (voices[v].note == key)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(v);
      end
      if (!voices[v].active) begin
        free     = 1'b1;
        free_idx = IDX_W'(v);
      end
    end
  end

`ifdef VOICE_STEAL_EN
  logic [AGE_W_MAX-1:0] best_age;

  // Strict compare keeps the lowest index on equal ages.
  always_comb begin
    oldest_idx = '0;
    best_age   = '0;
    for (int v = 0; v < N_VOICES; v++) begin
      if (voices[v].age > best_age) begin
        best_age   = voices[v].age;
        oldest_idx = IDX_W'(v);
      end
    end
  end
`else
  logic unused_age;

  always_comb begin
    unused_age = 1'b0;
    for (int v = 0; v < N_VOICES; v++) begin
      unused_age = unused_age ^ (^voices[v].age);
    end
  end
`endif

endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: scans one key per clock and binds pressed keys to oscillator voices.
// Define VOICE_STEAL_EN to steal the oldest voice when all voices are busy.
module voice_allocator
  import sass_pkg::*;
#(
  parameter int unsigned N_VOICES = 4,
  parameter int unsigned AGE_W    = 4
) (
  input  logic                    hwclk,
  input  logic                    n_rst,
  input  logic [NUM_KEYS-1:0]     piano_keys,
  output logic [4*N_VOICES-1:0]   voice_note,
  output logic [N_VOICES-1:0]     voice_active,
  output logic [N_VOICES-1:0]     voice_new,
  output logic                    sweep_done
);

  localparam int unsigned IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;

  note_t                 scan_idx_q, scan_idx_d;
  voice_t [N_VOICES-1:0] voices_q, voices_d;
  logic [N_VOICES-1:0]   new_q, new_d;
  logic                  sweep_done_q;

  logic                  last_key, pressed;
  logic                  hit, free;
  logic [IDX_W-1:0]      hit_idx, free_idx;

  assign last_key   = (scan_idx_q == note_t'(NUM_KEYS - 1));
  assign scan_idx_d = last_key ? '0 : scan_idx_q + 4'd1;
  assign pressed    = piano_keys[scan_idx_q];

`ifdef VOICE_STEAL_EN
  localparam logic [AGE_W_MAX-1:0] AGE_SAT = AGE_W_MAX'((1 << AGE_W) - 1);
  logic [IDX_W-1:0] oldest_idx;
`endif

  voice_pick #(
    .N_VOICES (N_VOICES),
    .IDX_W    (IDX_W)
  ) u_voice_pick (
    .voices     (voices_q),
    .key        (scan_idx_q),
    .hit        (hit),
    .hit_idx    (hit_idx),
    .free       (free),
    .free_idx   (free_idx)
`ifdef VOICE_STEAL_EN
    ,
    .oldest_idx (oldest_idx)
`endif
  );

  always_comb begin
    voices_d = voices_q;
    new_d    = '0;
`ifdef VOICE_STEAL_EN
    // Ages advance before allocation so a voice taken this cycle starts at zero.
    if (last_key) begin
      for (int v = 0; v < N_VOICES; v++) begin
        if (voices_d[v].active && (voices_d[v].age < AGE_SAT)) begin
          voices_d[v].age = voices_d[v].age + 1'b1;
        end
      end
    end
`endif
    if (pressed && !hit) begin
      if (free) begin
        voices_d[free_idx] = '{active: 1'b1, note: scan_idx_q, age: '0};
        new_d[free_idx]    = 1'b1;
      end
`ifdef VOICE_STEAL_EN
      else begin
        voices_d[oldest_idx] = '{active: 1'b1, note: scan_idx_q, age: '0};
        new_d[oldest_idx]    = 1'b1;
      end
`endif
    end else if (!pressed && hit) begin
      voices_d[hit_idx].active = 1'b0;
    end
  end

  always_ff @(posedge hwclk or negedge n_rst) begin
    if (!n_rst) begin
      scan_idx_q   <= '0;
      voices_q     <= '0;
      new_q        <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      scan_idx_q   <= scan_idx_d;
      voices_q     <= voices_d;
      new_q        <= new_d;
      sweep_done_q <= last_key;
    end
  end

  always_comb begin
    for (int v = 0; v < N_VOICES; v++) begin
      voice_note[4*v +: 4] = voices_q[v].note;
      voice_active[v]      = voices_q[v].active;
    end
  end

  assign voice_new  = new_q;
  assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator (N_VOICES=4, AGE_W=4).
module tb_voice_allocator;

  localparam int unsigned NV = 4;

  logic          hwclk = 1'b0;
  logic          n_rst = 1'b0;
  logic [14:0]   piano_keys = '0;
  logic [4*NV-1:0] voice_note;
  logic [NV-1:0] voice_active;
  logic [NV-1:0] voice_new;
  logic          sweep_done;

  int n_checks = 0;
  int n_errors = 0;
  int new_cnt[NV];
  int sd_cnt;
  int sd_first;

  voice_allocator #(
    .N_VOICES (NV),
    .AGE_W    (4)
  ) dut (
    .hwclk        (hwclk),
    .n_rst        (n_rst),
    .piano_keys   (piano_keys),
    .voice_note   (voice_note),
    .voice_active (voice_active),
    .voice_new    (voice_new),
    .sweep_done   (sweep_done)
  );

  always #5 hwclk = ~hwclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    for (int v = 0; v < NV; v++) new_cnt[v] = 0;
    sd_cnt = 0;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge hwclk);
      #1;
      for (int v = 0; v < NV; v++) new_cnt[v] += int'(voice_new[v]);
      sd_cnt += int'(sweep_done);
    end
  endtask

  // Expect exactly exp[v] new-note pulses per voice since the last clr().
  task automatic check_new(input string tag, input logic [NV-1:0] exp);
    for (int v = 0; v < NV; v++) begin
      check($sformatf("%s_v%0d", tag, v), new_cnt[v], {31'd0, exp[v]});
    end
  endtask

  task automatic restart(input logic [14:0] keys);
    @(negedge hwclk);
    n_rst      = 1'b0;
    piano_keys = keys;
    @(negedge hwclk);
    n_rst = 1'b1;
    clr();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset mid-sweep
    piano_keys = 15'h0010;
    #12;
    @(negedge hwclk);
    n_rst = 1'b1;
    clr();
    run(7);
    check("pre_rst_active", voice_active, 4'b0001);
    check("pre_rst_note", voice_note, 16'h0004);
    @(posedge hwclk);
    #3;
    n_rst = 1'b0;
    #1;
    check("rst_active", voice_active, 4'b0000);
    check("rst_new", voice_new, 4'b0000);
    check("rst_note", voice_note, 16'h0000);
    check("rst_sweep", sweep_done, 1'b0);

    // 2. Single key 0; scan must restart at key 0
    piano_keys = 15'h0001;
    @(negedge hwclk);
    n_rst = 1'b1;
    clr();
    sd_first = 0;
    for (int i = 1; i <= 15; i++) begin
      run(1);
      if (i == 1) begin
        check("t2_active", voice_active, 4'b0001);
        check("t2_new", voice_new, 4'b0001);
        check("t2_note", voice_note, 16'h0000);
      end
      if (i == 2) check("t2_new_off", voice_new, 4'b0000);
      if (sweep_done && (sd_first == 0)) sd_first = i;
    end
    check("t2_sweep_first", sd_first, 15);
    check_new("t2_cnt", 4'b0001);

    // 3. Keys 0,2,4
    piano_keys = 15'b000000000010101;
    clr();
    run(16);
    check("t3_active", voice_active, 4'b0111);
    check("t3_note", voice_note, 16'h0420);
    check_new("t3_cnt", 4'b0110);

    // 4. Release key 2, then press key 7
    piano_keys = 15'b000000000010001;
    clr();
    run(16);
    check("t4_rel_active", voice_active, 4'b0101);
    check("t4_rel_note", voice_note, 16'h0420);
    check_new("t4_rel_cnt", 4'b0000);
    piano_keys = 15'b000000010010001;
    clr();
    run(16);
    check("t4_active", voice_active, 4'b0111);
    check("t4_note", voice_note, 16'h0470);
    check_new("t4_cnt", 4'b0010);

    // 5. All voices busy, then one more key
    restart(15'h0055);
    run(16);
    check("t5_full_active", voice_active, 4'b1111);
    check("t5_full_note", voice_note, 16'h6420);
    check_new("t5_full_cnt", 4'b1111);
    piano_keys = 15'h0255;
    clr();
`ifdef VOICE_STEAL_EN
    run(9);
    check("t5_steal_active", voice_active, 4'b1111);
    check("t5_steal_note", voice_note, 16'h6429);
    check_new("t5_steal_cnt", 4'b0001);
`else
    run(16);
    check("t5_drop_active", voice_active, 4'b1111);
    check("t5_drop_note", voice_note, 16'h6420);
    check_new("t5_drop_cnt", 4'b0000);
    piano_keys = 15'h0245;
    clr();
    run(16);
    check("t5_retry_active", voice_active, 4'b1111);
    check("t5_retry_note", voice_note, 16'h6920);
    check_new("t5_retry_cnt", 4'b0100);
`endif

    // 6. Hold one key for 300 sweeps
    restart(15'h0008);
    run(15 * 300);
    check("t6_active", voice_active, 4'b0001);
    check("t6_note", voice_note, 16'h0003);
    check_new("t6_cnt", 4'b0001);
    check("t6_sweeps", sd_cnt, 300);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
